// File: rtl/dm_cmd_pkg.sv
// ---------------------------------------------------------------------------
// dm_cmd_pkg
// Shared definitions for the datamover command responder: command-word field
// offsets, status-byte bit positions and the per-channel FSM state encoding.
// ---------------------------------------------------------------------------
package dm_cmd_pkg;

    // Command word layout (72 bits)
    localparam int unsigned CMD_W     = 72;
    localparam int unsigned BTT_LSB   = 0;
    localparam int unsigned BTT_W     = 23;
    localparam int unsigned TYPE_BIT  = 23;
    localparam int unsigned DSA_LSB   = 24;
    localparam int unsigned DSA_W     = 6;
    localparam int unsigned EOF_BIT   = 30;
    localparam int unsigned DRR_BIT   = 31;
    localparam int unsigned SADDR_LSB = 32;
    localparam int unsigned SADDR_W   = 32;
    localparam int unsigned TAG_LSB   = 64;
    localparam int unsigned TAG_W     = 4;
    localparam int unsigned RSVD_LSB  = 68;
    localparam int unsigned RSVD_W    = 4;

    // Status byte layout
    localparam int unsigned STS_W          = 8;
    localparam int unsigned STS_TAG_LSB    = 0;
    localparam int unsigned STS_INTERR_BIT = 4;
    localparam int unsigned STS_DECERR_BIT = 5;
    localparam int unsigned STS_SLVERR_BIT = 6;
    localparam int unsigned STS_OKAY_BIT   = 7;

    // Per-channel FSM states
    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_BUSY = 2'd1,
        CH_STS  = 2'd2
    } chan_state_e;

endpackage : dm_cmd_pkg

// File: rtl/dm_chan_responder.sv
// ---------------------------------------------------------------------------
// dm_chan_responder
// One datamover channel: accepts a command, models a fixed-latency transfer
// of ceil(BTT / BYTES_PER_BEAT) beats, then presents a status byte until it
// is taken. A successful transfer also pulses xfer_cmplt alongside the first
// cycle of sts_tvalid.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_tdata/tvalid/tready   command stream (slave)
//   sts_tdata/tvalid/tready   status stream (master)
//   xfer_cmplt            one-cycle pulse on OKAY completion
//
// CMD_LATENCY must be at least 1.
// ---------------------------------------------------------------------------
module dm_chan_responder
    import dm_cmd_pkg::*;
#(
    parameter int unsigned BYTES_PER_BEAT = 4,
    parameter int unsigned CMD_LATENCY    = 4,
    parameter logic [31:0] ADDR_LIMIT     = 32'h4000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CMD_W-1:0] cmd_tdata,
    input  logic             cmd_tvalid,
    output logic             cmd_tready,
    output logic [STS_W-1:0] sts_tdata,
    output logic             sts_tvalid,
    input  logic             sts_tready,
    output logic             xfer_cmplt
);

    localparam int unsigned BEAT_SHIFT = $clog2(BYTES_PER_BEAT);
    localparam logic [23:0] ROUND_ADD  = 24'(BYTES_PER_BEAT - 1);
    localparam logic [31:0] LATENCY    = 32'(CMD_LATENCY);

    chan_state_e      state_q, state_d;
    logic [31:0]      cnt_q;       // BUSY cycles remaining after this one
    logic [STS_W-1:0] sts_q;
    logic             cmplt_q;
    logic             out_en_q;    // holds cmd_tready low until the first edge after reset

    // Command fields
    logic [BTT_W-1:0]   cmd_btt;
    logic               cmd_incr;
    logic [SADDR_W-1:0] cmd_saddr;
    logic [TAG_W-1:0]   cmd_tag;
    logic               unused_cmd_bits;

    assign cmd_btt   = cmd_tdata[BTT_LSB +: BTT_W];
    assign cmd_incr  = cmd_tdata[TYPE_BIT];
    assign cmd_saddr = cmd_tdata[SADDR_LSB +: SADDR_W];
    assign cmd_tag   = cmd_tdata[TAG_LSB +: TAG_W];
    assign unused_cmd_bits = ^{cmd_tdata[DSA_LSB +: DSA_W], cmd_tdata[EOF_BIT],
                               cmd_tdata[DRR_BIT], cmd_tdata[RSVD_LSB +: RSVD_W]};

    // Classification and BUSY duration, evaluated on the incoming command
    logic [23:0]      btt_rounded;
    logic [23:0]      beats;
    logic [32:0]      end_addr;
    logic             interr;
    logic             decerr;
    logic [31:0]      busy_load;
    logic [STS_W-1:0] sts_new;
    logic             accept;

    // NOTE: every signal driven from always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        btt_rounded = {1'b0, cmd_btt} + ROUND_ADD;   // 24 bits: cannot overflow
        beats       = btt_rounded >> BEAT_SHIFT;
        end_addr    = {1'b0, cmd_saddr} + {10'd0, cmd_btt};
        interr      = (cmd_btt == '0) || !cmd_incr;
        decerr      = !interr && (end_addr > {1'b0, ADDR_LIMIT});

        // Counter holds (cycles - 1) so BUSY lasts exactly the target count
        if (interr)
            busy_load = LATENCY - 32'd1;
        else
            busy_load = LATENCY + {8'd0, beats} - 32'd1;

        sts_new                               = '0;
        sts_new[STS_TAG_LSB +: TAG_W]         = cmd_tag;
        sts_new[STS_INTERR_BIT]               = interr;
        sts_new[STS_DECERR_BIT]               = decerr;
        sts_new[STS_SLVERR_BIT]               = 1'b0;
        sts_new[STS_OKAY_BIT]                 = !interr && !decerr;
    end

    assign cmd_tready = out_en_q && (state_q == CH_IDLE);
    assign accept     = cmd_tvalid && cmd_tready;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CH_IDLE: if (accept)          state_d = CH_BUSY;
            CH_BUSY: if (cnt_q == '0)     state_d = CH_STS;
            CH_STS:  if (sts_tready)      state_d = CH_IDLE;
            default:                      state_d = CH_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CH_IDLE;
            cnt_q    <= '0;
            sts_q    <= '0;
            cmplt_q  <= 1'b0;
            out_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_en_q <= 1'b1;
            if (accept) begin
                cnt_q <= busy_load;
                sts_q <= sts_new;
            end else if (state_q == CH_BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - 32'd1;
            end
            // Pulse aligned with the first STS cycle, only for OKAY
            cmplt_q <= (state_q == CH_BUSY) && (state_d == CH_STS) && sts_q[STS_OKAY_BIT];
        end
    end

    assign sts_tvalid = (state_q == CH_STS);
    assign sts_tdata  = sts_tvalid ? sts_q : '0;
    assign xfer_cmplt = cmplt_q;

endmodule : dm_chan_responder

// File: rtl/dm_cmd_responder.sv
// ---------------------------------------------------------------------------
// dm_cmd_responder
// Datamover command/status responder with independent MM2S (read) and S2MM
// (write) channels. Each channel accepts one 72-bit command at a time and
// returns one status byte after a modelled transfer.
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   s_axis_mm2s_cmd_*, s_axis_s2mm_cmd_*   command streams in
//   m_axis_mm2s_sts_*, m_axis_s2mm_sts_*   status streams out
//   mm2s_rd_xfer_cmplt, s2mm_wr_xfer_cmplt completion pulses
// ---------------------------------------------------------------------------
module dm_cmd_responder
    import dm_cmd_pkg::*;
#(
    parameter int unsigned BYTES_PER_BEAT = 4,
    parameter int unsigned CMD_LATENCY    = 4,
    parameter logic [31:0] ADDR_LIMIT     = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [71:0] s_axis_mm2s_cmd_tdata,
    input  logic        s_axis_mm2s_cmd_tvalid,
    output logic        s_axis_mm2s_cmd_tready,
    input  logic [71:0] s_axis_s2mm_cmd_tdata,
    input  logic        s_axis_s2mm_cmd_tvalid,
    output logic        s_axis_s2mm_cmd_tready,
    output logic [7:0]  m_axis_mm2s_sts_tdata,
    output logic        m_axis_mm2s_sts_tvalid,
    input  logic        m_axis_mm2s_sts_tready,
    output logic [7:0]  m_axis_s2mm_sts_tdata,
    output logic        m_axis_s2mm_sts_tvalid,
    input  logic        m_axis_s2mm_sts_tready,
    output logic        mm2s_rd_xfer_cmplt,
    output logic        s2mm_wr_xfer_cmplt
);

    dm_chan_responder #(
        .BYTES_PER_BEAT (BYTES_PER_BEAT),
        .CMD_LATENCY    (CMD_LATENCY),
        .ADDR_LIMIT     (ADDR_LIMIT)
    ) u_mm2s (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_tdata  (s_axis_mm2s_cmd_tdata),
        .cmd_tvalid (s_axis_mm2s_cmd_tvalid),
        .cmd_tready (s_axis_mm2s_cmd_tready),
        .sts_tdata  (m_axis_mm2s_sts_tdata),
        .sts_tvalid (m_axis_mm2s_sts_tvalid),
        .sts_tready (m_axis_mm2s_sts_tready),
        .xfer_cmplt (mm2s_rd_xfer_cmplt)
    );

    dm_chan_responder #(
        .BYTES_PER_BEAT (BYTES_PER_BEAT),
        .CMD_LATENCY    (CMD_LATENCY),
        .ADDR_LIMIT     (ADDR_LIMIT)
    ) u_s2mm (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_tdata  (s_axis_s2mm_cmd_tdata),
        .cmd_tvalid (s_axis_s2mm_cmd_tvalid),
        .cmd_tready (s_axis_s2mm_cmd_tready),
        .sts_tdata  (m_axis_s2mm_sts_tdata),
        .sts_tvalid (m_axis_s2mm_sts_tvalid),
        .sts_tready (m_axis_s2mm_sts_tready),
        .xfer_cmplt (s2mm_wr_xfer_cmplt)
    );

endmodule : dm_cmd_responder

// File: tb/tb_dm_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_dm_cmd_responder
// Directed, table-driven bench for dm_cmd_responder with default parameters
// (4 bytes/beat, latency 4, address limit 0x4000_0000). Latency is counted
// as rising edges from the accept edge until status is visible.
// ---------------------------------------------------------------------------
module tb_dm_cmd_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [71:0] mm2s_cmd_tdata, s2mm_cmd_tdata;
    logic        mm2s_cmd_tvalid, s2mm_cmd_tvalid;
    logic        mm2s_cmd_tready, s2mm_cmd_tready;
    logic [7:0]  mm2s_sts_tdata, s2mm_sts_tdata;
    logic        mm2s_sts_tvalid, s2mm_sts_tvalid;
    logic        mm2s_sts_tready, s2mm_sts_tready;
    logic        mm2s_cmplt, s2mm_cmplt;

    int tests = 0;
    int fails = 0;

    dm_cmd_responder dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .s_axis_mm2s_cmd_tdata  (mm2s_cmd_tdata),
        .s_axis_mm2s_cmd_tvalid (mm2s_cmd_tvalid),
        .s_axis_mm2s_cmd_tready (mm2s_cmd_tready),
        .s_axis_s2mm_cmd_tdata  (s2mm_cmd_tdata),
        .s_axis_s2mm_cmd_tvalid (s2mm_cmd_tvalid),
        .s_axis_s2mm_cmd_tready (s2mm_cmd_tready),
        .m_axis_mm2s_sts_tdata  (mm2s_sts_tdata),
        .m_axis_mm2s_sts_tvalid (mm2s_sts_tvalid),
        .m_axis_mm2s_sts_tready (mm2s_sts_tready),
        .m_axis_s2mm_sts_tdata  (s2mm_sts_tdata),
        .m_axis_s2mm_sts_tvalid (s2mm_sts_tvalid),
        .m_axis_s2mm_sts_tready (s2mm_sts_tready),
        .mm2s_rd_xfer_cmplt     (mm2s_cmplt),
        .s2mm_wr_xfer_cmplt     (s2mm_cmplt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ch;        // 0 = MM2S, 1 = S2MM
        logic [22:0] btt;
        bit          incr;
        logic [31:0] saddr;
        logic [3:0]  tag;
        int          exp_lat;
        logic [7:0]  exp_sts;
        bit          exp_cmplt;
        string       name;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Unused fields carry arbitrary non-zero content; they must be ignored.
    function automatic logic [71:0] mk_cmd(input logic [22:0] btt, input bit incr,
                                           input logic [31:0] saddr, input logic [3:0] tag);
        return {4'h5, tag, saddr, 1'b1, 1'b0, 6'h2A, incr, btt};
    endfunction

    function automatic logic get_tready(input bit ch);
        return ch ? s2mm_cmd_tready : mm2s_cmd_tready;
    endfunction
    function automatic logic get_sts_valid(input bit ch);
        return ch ? s2mm_sts_tvalid : mm2s_sts_tvalid;
    endfunction
    function automatic logic [7:0] get_sts(input bit ch);
        return ch ? s2mm_sts_tdata : mm2s_sts_tdata;
    endfunction
    function automatic logic get_cmplt(input bit ch);
        return ch ? s2mm_cmplt : mm2s_cmplt;
    endfunction

    task automatic drive_cmd(input bit ch, input logic [71:0] cmd);
        if (ch) begin
            s2mm_cmd_tdata  = cmd;
            s2mm_cmd_tvalid = 1'b1;
        end else begin
            mm2s_cmd_tdata  = cmd;
            mm2s_cmd_tvalid = 1'b1;
        end
    endtask

    task automatic drop_cmd(input bit ch);
        if (ch) s2mm_cmd_tvalid = 1'b0;
        else    mm2s_cmd_tvalid = 1'b0;
    endtask

    // Present a command, wait (bounded) for tready, return just after the accept edge.
    task automatic send(input bit ch, input logic [71:0] cmd, input string name);
        int n;
        @(negedge clk);
        drive_cmd(ch, cmd);
        n = 0;
        while (!get_tready(ch) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "/cmd_tready"}, 32'(get_tready(ch)), 32'd1);
        @(posedge clk);
        #1 drop_cmd(ch);
    endtask

    // Count edges from the accept edge until status is visible; flag any early cmplt.
    task automatic wait_sts(input bit ch, input int budget, output int lat, output bit early);
        lat   = 0;
        early = 1'b0;
        while (lat <= budget) begin
            @(negedge clk);
            if (get_sts_valid(ch)) return;
            if (get_cmplt(ch)) early = 1'b1;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "/mm2s_tready"}, 32'(mm2s_cmd_tready), 32'd0);
        check({name, "/s2mm_tready"}, 32'(s2mm_cmd_tready), 32'd0);
        check({name, "/sts_tvalid"},  32'({mm2s_sts_tvalid, s2mm_sts_tvalid}), 32'd0);
        check({name, "/cmplt"},       32'({mm2s_cmplt, s2mm_cmplt}), 32'd0);
        check({name, "/sts_tdata"},   32'({mm2s_sts_tdata, s2mm_sts_tdata}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  early;
        bit  bad;

        // ch, btt, incr, saddr, tag, latency, status, cmplt
        vecs[0] = '{1'b0, 23'd16, 1'b1, 32'h0000_1000, 4'h3,  8, 8'h83, 1'b1, "rd_btt16_okay"};
        vecs[1] = '{1'b0, 23'd0,  1'b1, 32'h0000_0000, 4'h1,  4, 8'h11, 1'b0, "rd_btt0_interr"};
        vecs[2] = '{1'b0, 23'd32, 1'b1, 32'h3FFF_FFF0, 4'h0, 12, 8'h20, 1'b0, "rd_decerr"};
        vecs[3] = '{1'b1, 23'd1,  1'b0, 32'h0000_0100, 4'h5,  4, 8'h15, 1'b0, "wr_fixed_interr"};
        vecs[4] = '{1'b1, 23'd4,  1'b1, 32'h3FFF_FFFC, 4'h7,  5, 8'h87, 1'b1, "wr_end_at_limit"};
        vecs[5] = '{1'b1, 23'd5,  1'b1, 32'h3FFF_FFFC, 4'h2,  6, 8'h22, 1'b0, "wr_end_past_limit"};
        vecs[6] = '{1'b0, 23'd7,  1'b1, 32'h0000_0000, 4'hF,  6, 8'h8F, 1'b1, "rd_btt7_round_up"};
        vecs[7] = '{1'b0, 23'd1,  1'b1, 32'hFFFF_FFFF, 4'h4,  5, 8'h24, 1'b0, "rd_33bit_carry"};
        vecs[8] = '{1'b1, 23'd9,  1'b1, 32'h0000_2000, 4'h6,  7, 8'h86, 1'b1, "wr_btt9"};
        vecs[9] = '{1'b0, 23'd0,  1'b1, 32'hFFFF_FFF0, 4'h9,  4, 8'h19, 1'b0, "rd_interr_over_decerr"};

        mm2s_cmd_tdata  = '0;
        s2mm_cmd_tdata  = '0;
        mm2s_cmd_tvalid = 1'b0;
        s2mm_cmd_tvalid = 1'b0;
        mm2s_sts_tready = 1'b1;
        s2mm_sts_tready = 1'b1;

        // Reset state
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("release/no_edge_yet_tready", 32'(mm2s_cmd_tready), 32'd0);
        @(negedge clk);
        check("release/tready_both", 32'({mm2s_cmd_tready, s2mm_cmd_tready}), 32'b11);

        // Table: sts_tready held high, so status is taken in its first cycle
        for (int i = 0; i < NV; i++) begin
            send(vecs[i].ch, mk_cmd(vecs[i].btt, vecs[i].incr, vecs[i].saddr, vecs[i].tag), vecs[i].name);
            wait_sts(vecs[i].ch, 40, lat, early);
            check({vecs[i].name, "/latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "/status"},  32'(get_sts(vecs[i].ch)), 32'(vecs[i].exp_sts));
            check({vecs[i].name, "/cmplt"},   32'(get_cmplt(vecs[i].ch)), 32'(vecs[i].exp_cmplt));
            check({vecs[i].name, "/early_cmplt"}, 32'(early), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check({vecs[i].name, "/tready_back"}, 32'(get_tready(vecs[i].ch)), 32'd1);
            check({vecs[i].name, "/sts_dropped"}, 32'(get_sts_valid(vecs[i].ch)), 32'd0);
            check({vecs[i].name, "/cmplt_one_cycle"}, 32'(get_cmplt(vecs[i].ch)), 32'd0);
        end

        // Write with status back-pressure and a second command stalled behind it
        s2mm_sts_tready = 1'b0;
        send(1'b1, mk_cmd(23'd5, 1'b1, 32'h0000_2000, 4'hA), "bp");
        wait_sts(1'b1, 40, lat, early);
        check("bp/latency", 32'(lat), 32'd6);
        check("bp/status",  32'(s2mm_sts_tdata), 32'h8A);
        check("bp/cmplt",   32'(s2mm_cmplt), 32'd1);
        drive_cmd(1'b1, mk_cmd(23'd4, 1'b1, 32'h0000_3000, 4'hB));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp/held_status", 32'({s2mm_sts_tvalid, s2mm_sts_tdata}), 32'h18A);
            check("bp/held_cmplt_low", 32'(s2mm_cmplt), 32'd0);
            check("bp/held_tready_low", 32'(s2mm_cmd_tready), 32'd0);
        end
        s2mm_sts_tready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp/tready_after_hs", 32'(s2mm_cmd_tready), 32'd1);
        check("bp/sts_gone", 32'(s2mm_sts_tvalid), 32'd0);
        @(posedge clk);
        #1 drop_cmd(1'b1);
        wait_sts(1'b1, 40, lat, early);
        check("stalled/latency", 32'(lat), 32'd5);
        check("stalled/status",  32'(s2mm_sts_tdata), 32'h8B);
        check("stalled/cmplt",   32'(s2mm_cmplt), 32'd1);
        @(posedge clk);

        // Simultaneous accept on both channels
        @(negedge clk);
        drive_cmd(1'b0, mk_cmd(23'd4, 1'b1, 32'h0000_0040, 4'h1));
        drive_cmd(1'b1, mk_cmd(23'd4, 1'b1, 32'h0000_0080, 4'h2));
        check("dual/tready_both", 32'({mm2s_cmd_tready, s2mm_cmd_tready}), 32'b11);
        @(posedge clk);
        #1;
        drop_cmd(1'b0);
        drop_cmd(1'b1);
        wait_sts(1'b0, 40, lat, early);
        check("dual/latency", 32'(lat), 32'd5);
        check("dual/cmplt_both", 32'({mm2s_cmplt, s2mm_cmplt}), 32'b11);
        check("dual/status_both", 32'({mm2s_sts_tdata, s2mm_sts_tdata}), 32'h8182);
        @(posedge clk);

        // Reset in the middle of BUSY
        send(1'b0, mk_cmd(23'd16, 1'b1, 32'h0000_1000, 4'h3), "rst_busy");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1 check_idle_outputs("rst_busy/in_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy/tready_after", 32'(mm2s_cmd_tready), 32'd1);
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (mm2s_sts_tvalid || mm2s_cmplt) bad = 1'b1;
        end
        check("rst_busy/no_status_or_cmplt", 32'(bad), 32'd0);
        send(1'b0, mk_cmd(23'd8, 1'b1, 32'h0000_0000, 4'h2), "post_rst");
        wait_sts(1'b0, 40, lat, early);
        check("post_rst/latency", 32'(lat), 32'd6);
        check("post_rst/status",  32'(mm2s_sts_tdata), 32'h82);
        check("post_rst/cmplt",   32'(mm2s_cmplt), 32'd1);
        @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_dm_cmd_responder

// File: doc/dm_cmd_responder.md
DM_CMD_RESPONDER -- requirements
Module: dm_cmd_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BYTES_PER_BEAT, 4, data bus width in bytes; power of two.
- CMD_LATENCY, 4, fixed cycles from command accept to first data beat.
- ADDR_LIMIT, 32'h4000_0000, exclusive upper bound of the decodable address space.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_axis_mm2s_cmd_tdata  in  72  MM2S (read) command word.
- s_axis_mm2s_cmd_tvalid  in  1  MM2S command valid.
- s_axis_mm2s_cmd_tready  out  1  MM2S command ready.
- s_axis_s2mm_cmd_tdata  in  72  S2MM (write) command word.
- s_axis_s2mm_cmd_tvalid  in  1  S2MM command valid.
- s_axis_s2mm_cmd_tready  out  1  S2MM command ready.
- m_axis_mm2s_sts_tdata  out  8  MM2S status byte.
- m_axis_mm2s_sts_tvalid  out  1  MM2S status valid.
- m_axis_mm2s_sts_tready  in  1  MM2S status ready.
- m_axis_s2mm_sts_tdata  out  8  S2MM status byte.
- m_axis_s2mm_sts_tvalid  out  1  S2MM status valid.
- m_axis_s2mm_sts_tready  in  1  S2MM status ready.
- mm2s_rd_xfer_cmplt  out  1  one-cycle pulse on successful read completion.
- s2mm_wr_xfer_cmplt  out  1  one-cycle pulse on successful write completion.
REQ-003 Command field layout SHALL be: [22:0] BTT, [23] TYPE (1=INCR), [29:24] DSA, [30] EOF, [31] DRR, [63:32] SADDR, [67:64] TAG, [71:68] reserved.
REQ-004 Status byte layout SHALL be: [3:0] TAG, [4] INTERR, [5] DECERR, [6] SLVERR (always 0), [7] OKAY.

Function
REQ-005 Each channel SHALL run an independent FSM with states IDLE, BUSY, STS.
REQ-006 cmd_tready SHALL be 1 only in IDLE; a command SHALL be accepted when tvalid and tready are both 1, latching BTT, TYPE, SADDR and TAG, and moving the FSM to BUSY.
REQ-007 The beat count SHALL be (BTT + BYTES_PER_BEAT-1) / BYTES_PER_BEAT, computed at 24-bit width with no overflow.
REQ-008 The FSM SHALL stay in BUSY for exactly CMD_LATENCY + beats cycles, then enter STS.
REQ-009 Error classification SHALL use the following priority:
- BTT==0 or TYPE==0: INTERR=1, and BUSY lasts CMD_LATENCY cycles only.
- Otherwise, SADDR+BTT (33-bit arithmetic) > ADDR_LIMIT: DECERR=1.
- Otherwise: OKAY=1.
REQ-010 On the BUSY-to-STS transition, sts_tvalid SHALL rise in the same cycle as xfer_cmplt pulses high for one cycle; xfer_cmplt SHALL pulse only when OKAY=1.
REQ-011 sts_tvalid and sts_tdata SHALL hold stable until sts_tready=1; the FSM SHALL then return to IDLE, and tready SHALL rise the next cycle (at most one command in flight per channel).
REQ-012 If sts_tready is already 1 when STS is entered, the handshake SHALL complete in that first STS cycle.
REQ-013 Simultaneous MM2S and S2MM accepts SHALL both be honoured in the same cycle, with no cross-channel interaction.
REQ-014 Commands whose tvalid is asserted outside IDLE SHALL be stalled, never dropped.

Reset
REQ-015 While rst_n=0, both FSMs SHALL be in IDLE, and all cmd_tready, sts_tvalid, xfer_cmplt and sts_tdata outputs SHALL be 0; reset asserted mid-transfer SHALL abort the transfer with no status and no cmplt.
REQ-016 Reset release SHALL take effect on a clk edge; cmd_tready SHALL be 1 in the first cycle after release.

Structure
REQ-017 Command and status field offsets, FSM state encodings and status-bit positions SHALL live in the shared package dm_cmd_pkg.
REQ-018 One sub-module, dm_chan_responder, SHALL implement a single channel and SHALL be instantiated twice.

Verification
REQ-019 Read with BTT=16, SADDR=0x1000, TAG=3: mm2s_rd_xfer_cmplt pulses 8 cycles after accept, and status = 0x83.
REQ-020 Write with BTT=5, TAG=0xA, and sts_tready held 0 for 3 cycles: s2mm_wr_xfer_cmplt pulses 6 cycles after accept, status 0x8A is held stable for 3 cycles, and tready returns 1 cycle after the handshake.
REQ-021 Read with BTT=0, TAG=1: status 0x11 after 4 cycles, and no cmplt pulse.
REQ-022 Read with SADDR=0x3FFF_FFF0, BTT=32: status DECERR (0x2x), and no cmplt pulse.
REQ-023 MM2S and S2MM commands accepted in the same cycle (BTT=4 each): both cmplt pulses occur 5 cycles later, in the same cycle.
REQ-024 rst_n deasserted low during BUSY: no status, no cmplt; after release, tready=1 and a new command completes normally.
